// File: rtl/imm_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_stage : registered immediate-generation stage with a 2-entry skid buffer
// Optional feature macro: IMM_ILLEGAL_CHECK_EN (flag non-one-hot formats)
// Revision  : 1.0
// ---------------------------------------------------------------------------
module imm_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_inst,
   input  logic [6:0]       i_format,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_immediate,
   output logic [6:0]       o_format,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_illegal
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic [31:0]       imm32;
   logic [XLEN-1:0]   imm_ext;
   logic [XLEN-1:0]   new_imm;
   logic              new_illegal;
   logic              accept;
   logic              consume;
   logic [XLEN-1:0]   skid_imm;
   logic [6:0]        skid_format;
   logic [TAG_W-1:0]  skid_tag;
   logic              skid_illegal;
   logic              unused_opcode;

   assign unused_opcode = ^i_inst[6:0];

   // Lowest set format bit wins; all-zero falls through to R (zero).
   always_comb begin
      imm32 = 32'd0;
      if (i_format[0])
         imm32 = 32'd0;
      else if (i_format[1])
         imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      else if (i_format[2])
         imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      else if (i_format[3])
         imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      else if (i_format[4])
         imm32 = {i_inst[31:12], 12'd0};
      else if (i_format[5])
         imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      else if (i_format[6])
         imm32 = {27'd0, i_inst[19:15]};
   end

   generate
      if (XLEN > 32) begin : g_ext_wide
         assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
      end else begin : g_ext_narrow
         assign imm_ext = imm32[XLEN-1:0];
      end
   endgenerate

`ifdef IMM_ILLEGAL_CHECK_EN
   assign new_illegal = (i_format == 7'd0) || ((i_format & (i_format - 7'd1)) != 7'd0);
   assign new_imm     = new_illegal ? '0 : imm_ext;
`else
   assign new_illegal = 1'b0;
   assign new_imm     = imm_ext;
`endif

   assign accept  = i_valid && o_ready;
   assign consume = o_valid && i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= EMPTY;
         o_valid      <= 1'b0;
         o_ready      <= 1'b1;
         o_immediate  <= '0;
         o_format     <= '0;
         o_tag        <= '0;
         o_illegal    <= 1'b0;
         skid_imm     <= '0;
         skid_format  <= '0;
         skid_tag     <= '0;
         skid_illegal <= 1'b0;
      end else if (i_flush) begin
         state   <= EMPTY;
         o_valid <= 1'b0;
         o_ready <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  o_immediate <= new_imm;
                  o_format    <= i_format;
                  o_tag       <= i_tag;
                  o_illegal   <= new_illegal;
                  o_valid     <= 1'b1;
                  state       <= ONE;
               end
            end
            ONE: begin
               if (accept && !consume) begin
                  skid_imm     <= new_imm;
                  skid_format  <= i_format;
                  skid_tag     <= i_tag;
                  skid_illegal <= new_illegal;
                  o_ready      <= 1'b0;
                  state        <= TWO;
               end else if (consume && !accept) begin
                  o_valid <= 1'b0;
                  state   <= EMPTY;
               end else if (accept && consume) begin
                  o_immediate <= new_imm;
                  o_format    <= i_format;
                  o_tag       <= i_tag;
                  o_illegal   <= new_illegal;
               end
            end
            TWO: begin
               // o_ready is low here, so only a drain can happen.
               if (consume) begin
                  o_immediate <= skid_imm;
                  o_format    <= skid_format;
                  o_tag       <= skid_tag;
                  o_illegal   <= skid_illegal;
                  o_ready     <= 1'b1;
                  state       <= ONE;
               end
            end
            default: begin
               state   <= EMPTY;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imm_stage.sv
`default_nettype none
// tb_imm_stage : scoreboard bench driving a 32-bit and a 64-bit imm_stage in lockstep.
module tb_imm_stage;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             valid;
   logic             rdy;
   logic [31:0]      inst;
   logic [6:0]       fmt;
   logic [TAG_W-1:0] tag;

   logic             ready32, valid32, ill32;
   logic [31:0]      imm32;
   logic [6:0]       fmt32;
   logic [TAG_W-1:0] tag32;
   logic             ready64, valid64, ill64;
   logic [63:0]      imm64;
   logic [6:0]       fmt64;
   logic [TAG_W-1:0] tag64;

   always #5 clk = ~clk;

   imm_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready32),
      .i_inst(inst), .i_format(fmt), .i_tag(tag), .o_valid(valid32), .i_ready(rdy),
      .o_immediate(imm32), .o_format(fmt32), .o_tag(tag32), .o_illegal(ill32)
   );

   imm_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready64),
      .i_inst(inst), .i_format(fmt), .i_tag(tag), .o_valid(valid64), .i_ready(rdy),
      .o_immediate(imm64), .o_format(fmt64), .o_tag(tag64), .o_illegal(ill64)
   );

   typedef struct {
      logic [63:0]      imm;
      logic [6:0]       fmt;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } beat_t;

   beat_t q[$];
   int    n_vec = 0;
   int    n_err = 0;
   beat_t pend_b;
   bit    pend_acc = 0;
   bit    pend_fl  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: immediates built arithmetically from a 64-bit signed view of inst.
   function automatic beat_t model(input logic [31:0] in, input logic [6:0] f, input logic [TAG_W-1:0] t);
      beat_t  b;
      longint s;
      longint u;
      int     first;
      s = longint'($signed(in));
      u = longint'({32'd0, in});
      first = -1;
      for (int k = 6; k >= 0; k--)
         if (f[k]) first = k;
      case (first)
         1: b.imm = s >>> 20;
         2: b.imm = ((s >>> 25) <<< 5) | ((u >> 7) & 31);
         3: b.imm = ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11) |
                    (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
         4: b.imm = s & ~longint'(4095);
         5: b.imm = ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12) |
                    (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
         6: b.imm = (u >> 15) & 31;
         default: b.imm = 64'd0;
      endcase
      b.fmt = f;
      b.tag = t;
`ifdef IMM_ILLEGAL_CHECK_EN
      b.ill = ($countones(f) != 1);
      if (b.ill) b.imm = 64'd0;
`else
      b.ill = 1'b0;
`endif
      return b;
   endfunction

   // Monitor: outputs are stable at the falling edge; compare against the queue head.
   always @(negedge clk) begin
      check("valid32", {63'd0, valid32}, {63'd0, q.size() != 0});
      check("valid64", {63'd0, valid64}, {63'd0, q.size() != 0});
      check("ready32", {63'd0, ready32}, {63'd0, q.size() < 2});
      check("ready64", {63'd0, ready64}, {63'd0, q.size() < 2});
      if (q.size() != 0) begin
         check("imm32", {32'd0, imm32}, {32'd0, q[0].imm[31:0]});
         check("imm64", imm64, q[0].imm);
         check("fmt", {57'd0, fmt32}, {57'd0, q[0].fmt});
         check("tag", {{(64-TAG_W){1'b0}}, tag32}, {{(64-TAG_W){1'b0}}, q[0].tag});
         check("tag64", {{(64-TAG_W){1'b0}}, tag64}, {{(64-TAG_W){1'b0}}, q[0].tag});
         check("illegal", {62'd0, ill32, ill64}, {62'd0, q[0].ill, q[0].ill});
         check("fmt64", {57'd0, fmt64}, {57'd0, q[0].fmt});
         if (rdy) void'(q.pop_front());
      end
   end

   task automatic step(input logic v, input logic [31:0] in, input logic [6:0] f,
                       input logic [TAG_W-1:0] t, input logic r, input logic fl);
      @(posedge clk);
      #1;
      if (pend_fl) q.delete();
      else if (pend_acc) q.push_back(pend_b);
      valid = v; inst = in; fmt = f; tag = t; rdy = r; flush = fl;
      pend_acc = v && (q.size() < 2);
      pend_fl  = fl;
      pend_b   = model(in, f, t);
   endtask

   task automatic check_reset_outputs();
      check("rst_valid", {62'd0, valid32, valid64}, 64'd0);
      check("rst_ready", {62'd0, ready32, ready64}, 64'd3);
      check("rst_imm", {32'd0, imm32} | imm64, 64'd0);
      check("rst_fmt", {57'd0, fmt32 | fmt64}, 64'd0);
      check("rst_tag", {{(64-TAG_W){1'b0}}, tag32 | tag64}, 64'd0);
      check("rst_ill", {62'd0, ill32, ill64}, 64'd0);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst = 1'b1; valid = 1'b0; flush = 1'b0;
      pend_acc = 0; pend_fl = 0;
      q.delete();
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy = 1'b0;
      inst = 32'd0; fmt = 7'd0; tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Format examples, streaming with downstream always ready.
      step(1, 32'hFFF00093, 7'h02, 5'd1, 1, 0);
      step(1, 32'h123450B7, 7'h10, 5'd2, 1, 0);
      step(1, 32'h800000B7, 7'h10, 5'd3, 1, 0);
      step(1, 32'hFE000EE3, 7'h08, 5'd4, 1, 0);
      step(1, 32'h004000EF, 7'h20, 5'd5, 1, 0);
      step(1, 32'h3401F073, 7'h40, 5'd6, 1, 0);
      step(1, 32'hFFF00093, 7'h06, 5'd7, 1, 0);
      step(1, 32'hFFF00093, 7'h00, 5'd8, 1, 0);
      step(1, 32'hABCDE123, 7'h04, 5'd9, 1, 0);
      step(0, 32'd0, 7'd0, 5'd0, 1, 0);
      step(0, 32'd0, 7'd0, 5'd0, 1, 0);

      // Backpressure: fill both entries, hold tag 3, then drain in order.
      step(1, 32'h00100093, 7'h02, 5'd1, 0, 0);
      step(1, 32'h00200093, 7'h02, 5'd2, 0, 0);
      step(1, 32'h00300093, 7'h02, 5'd3, 0, 0);
      step(1, 32'h00300093, 7'h02, 5'd3, 0, 0);
      step(1, 32'h00300093, 7'h02, 5'd3, 1, 0);
      step(1, 32'h00300093, 7'h02, 5'd3, 1, 0);
      repeat (3) step(0, 32'd0, 7'd0, 5'd0, 1, 0);

      // Flush while full, with a beat offered alongside.
      step(1, 32'h00400093, 7'h02, 5'd4, 0, 0);
      step(1, 32'h00500093, 7'h02, 5'd5, 0, 0);
      step(1, 32'h00600093, 7'h02, 5'd6, 0, 1);
      repeat (2) step(0, 32'd0, 7'd0, 5'd0, 1, 0);

      // Asynchronous reset with beats held.
      step(1, 32'h00700093, 7'h02, 5'd7, 0, 0);
      step(1, 32'h00800093, 7'h02, 5'd8, 0, 0);
      mid_reset();

      for (int i = 0; i < 3000; i++) begin
         logic [6:0] f;
         if ($urandom_range(0, 7) == 0) f = 7'($urandom);
         else f = 7'(1 << $urandom_range(0, 6));
         step($urandom_range(0, 3) != 0, $urandom, f, TAG_W'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
         if (i == 1500) mid_reset();
      end
      repeat (4) step(0, 32'd0, 7'd0, 5'd0, 1, 0);
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
